lfsr_rng: RTL and testbench
===========================

Name: lfsr_rng

Overview:
- Parametrised Fibonacci LFSR pseudo-random source. It replaces the fixed 8-bit generator used by game logic such as obstacle spawning and spacing.
- Adds configurable width, tap mask and seed, run-time reseed and free-run stepping.
- Adds a request/response "draw" handshake. Each draw returns OUT_W freshly generated feedback bits, so successive draws share no overlapping state bits.

Parameters:
- WIDTH, 8, LFSR register width (legal range 3..32).
- TAPS, 8'hB8, feedback mask, WIDTH bits wide; bit i set means state[i] feeds the XOR.
- SEED, 8'hB8, reset and fallback state, WIDTH bits wide; must be non-zero.
- OUT_W, 4, bits returned per draw (legal range 1..32).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- seed_load  in  1  load seed_in into the LFSR this cycle.
- seed_in  in  WIDTH  new seed value.
- step_en  in  1  free-run advance, one step per cycle, honoured only in IDLE.
- req_valid  in  1  draw request.
- req_ready  out  1  draw request can be accepted.
- out_valid  out  1  out_data holds a completed draw.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OUT_W  draw result.
- state  out  WIDTH  current LFSR contents.
- lockup  out  1  sticky all-zero detect; meaningful only with the optional feature.

Behaviour:
- Reset (rst=0, asynchronous): state=SEED, FSM=IDLE, out_valid=0, out_data=0, lockup=0. req_ready=1 after reset releases.
- Step rule:
  - fb = XOR of state[i] over every i where TAPS[i]=1.
  - next state = {state[WIDTH-2:0], fb}.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: req_ready=1 unless seed_load=1.
    - If req_valid && req_ready, go to SHIFT with bit counter=0. No step occurs on the acceptance cycle.
    - Otherwise, if step_en=1, perform one step.
  - SHIFT: one step per cycle, unconditionally; step_en is ignored.
    - Each fb is shifted into the LSB of the collect register, so the first fb ends up as the MSB of out_data.
    - After OUT_W steps, go to DONE. out_data and out_valid=1 appear OUT_W cycles after acceptance.
  - DONE: LFSR frozen; out_valid=1 and out_data stable.
    - out_ready=1 -> out_valid=0 and return to IDLE next cycle.
    - A new request can be accepted no earlier than the following cycle.
- seed_load has highest priority, in any state.
  - state <= seed_in and the FSM returns to IDLE.
  - An in-flight draw (SHIFT or DONE) is discarded: out_valid=0 and out_data keeps its old value.
  - The seed_load cycle does not step the LFSR.
- seed_load together with req_valid in the same cycle: the load wins and the request is not accepted (req_ready=0).
- Zero state with the feature disabled:
  - Loading all-zero produces a stuck all-zero sequence.
  - Draws still complete and return 0.
- Counter width is $clog2(OUT_W+1). OUT_W greater than WIDTH is legal.

Optional Feature:
- Macro: LFSR_LOCKUP_GUARD_EN.
- With the macro defined:
  - A seed_load of all-zero loads SEED instead and sets lockup=1.
  - If state is ever all-zero, the next cycle reloads SEED, sets lockup=1, and this has priority below seed_load.
  - lockup is sticky; only reset clears it.
- Without the macro: lockup is tied 0, and zero seeds load as given.

Test Plan:
1. Reset with WIDTH=8, TAPS=8'hB8 -> state=B8. Then step_en=1 for 4 cycles -> state sequence 70, E0, C0, 81.
2. From reset, request accepted at cycle t (OUT_W=4) -> out_valid=1 at t+4 with out_data=4'b0001 and state=81. Holding out_ready=0 keeps both stable. out_ready=1 returns the FSM to IDLE and req_ready=1 the next cycle.
3. seed_load=1 with seed_in=8'h01 during SHIFT -> draw aborted, out_valid never asserts, state=01. The next step gives state=02.
4. step_en=1 held during SHIFT and DONE -> no extra steps; state after the draw equals the no-step_en case (81).
5. LFSR_LOCKUP_GUARD_EN defined: seed_load with seed_in=0 -> state=B8, lockup=1, held until rst=0 clears it. Undefined: state=00 stays 00, a draw returns 0, lockup=0.
6. Assert rst=0 asynchronously mid-SHIFT, between clock edges -> state=B8, out_valid=0 immediately, FSM=IDLE.

Source files
------------

// File: rtl/lfsr_rng.sv
// lfsr_rng
// Parametrised Fibonacci LFSR pseudo-random source. It provides free-run
// stepping, run-time reseed, and a request/response draw handshake. Each draw
// returns OUT_W freshly generated feedback bits, oldest bit in the MSB.
//
// Optional build macro: LFSR_LOCKUP_GUARD_EN
//   When defined, an all-zero seed load or an all-zero state is replaced
//   by SEED, and the sticky lockup flag is raised. Only reset clears the flag.
//   When undefined, lockup is tied low and zero seeds load as given.
module lfsr_rng #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hB8),
    parameter int unsigned      OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             step_en,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [WIDTH-1:0] state,
    output logic             lockup
);

    localparam int unsigned      CNT_W = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(OUT_W - 1);
    // The collect register only needs the bits that precede the final
    // feedback bit; the last bit goes straight into out_data.
    localparam int unsigned      COL_W = (OUT_W > 1) ? OUT_W - 1 : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } fsm_t;

    fsm_t             fsm;
    logic [WIDTH-1:0] lfsr;
    logic [CNT_W-1:0] cnt;
    logic [COL_W-1:0] collect;

    logic             fb;
    logic [WIDTH-1:0] stepped;
    logic [OUT_W-1:0] draw_next;

    assign state = lfsr;

    // Feedback bit and the one-step successor of the current LFSR contents
    always_comb begin
        fb      = ^(lfsr & TAPS);
        stepped = {lfsr[WIDTH-2:0], fb};
    end

    // Draw value with this cycle's feedback bit appended as the new LSB
    generate
        if (OUT_W > 1) begin : g_draw_wide
            assign draw_next = {collect, fb};
        end else begin : g_draw_narrow
            assign draw_next = fb;
        end
    endgenerate

    // Requests are only taken in IDLE, and a seed load this cycle refuses them
    always_comb begin
        req_ready = (fsm == IDLE) && !seed_load;
    end

`ifdef LFSR_LOCKUP_GUARD_EN
    logic lockup_q;

    assign lockup = lockup_q;

    // LFSR, draw FSM, registered outputs and sticky lockup guard
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr      <= SEED;
            fsm       <= IDLE;
            cnt       <= '0;
            collect   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            lockup_q  <= 1'b0;
        end else if (seed_load) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            if (seed_in == '0) begin
                lfsr     <= SEED;
                lockup_q <= 1'b1;
            end else begin
                lfsr <= seed_in;
            end
        end else begin
            case (fsm)
                IDLE: begin
                    if (req_valid) begin
                        fsm     <= SHIFT;
                        cnt     <= '0;
                        collect <= '0;
                    end else if (step_en) begin
                        lfsr <= stepped;
                    end
                end
                SHIFT: begin
                    lfsr    <= stepped;
                    collect <= draw_next[COL_W-1:0];
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= draw_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
            // A stuck all-zero state is replaced by SEED, which overrides any step
            if (lfsr == '0) begin
                lfsr     <= SEED;
                lockup_q <= 1'b1;
            end
        end
    end
`else
    assign lockup = 1'b0;

    // LFSR, draw FSM and registered outputs; zero seeds load as given
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr      <= SEED;
            fsm       <= IDLE;
            cnt       <= '0;
            collect   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (seed_load) begin
            lfsr      <= seed_in;
            fsm       <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (req_valid) begin
                        fsm     <= SHIFT;
                        cnt     <= '0;
                        collect <= '0;
                    end else if (step_en) begin
                        lfsr <= stepped;
                    end
                end
                SHIFT: begin
                    lfsr    <= stepped;
                    collect <= draw_next[COL_W-1:0];
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= draw_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng
// Directed scenarios followed by randomized stimulus for lfsr_rng with default
// parameters. Each cycle is compared against a behavioural model. The model
// precomputes every draw with plain arithmetic at the moment it is accepted.
// It honours LFSR_LOCKUP_GUARD_EN in the same way as the design.
module tb_lfsr_rng;

    localparam int         WIDTH = 8;
    localparam int         OUT_W = 4;
    localparam logic [7:0] TAPS  = 8'hB8;
    localparam logic [7:0] SEED  = 8'hB8;

    localparam int P_IDLE = 0;
    localparam int P_BUSY = 1;
    localparam int P_DONE = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             seed_load = 1'b0;
    logic [WIDTH-1:0] seed_in = '0;
    logic             step_en = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic [WIDTH-1:0] state;
    logic             lockup;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int mState;
    int mPhase;
    int mLeft;
    int mDraw;
    int mOutData;
    bit mOutValid;
    bit mLockup;

    lfsr_rng #(
        .WIDTH(WIDTH),
        .TAPS (TAPS),
        .SEED (SEED),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .seed_load(seed_load),
        .seed_in  (seed_in),
        .step_en  (step_en),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .state    (state),
        .lockup   (lockup)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // Parity of the tapped bits of s
    function automatic int feedback(input int s);
        int ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (TAPS[i] && (((s >> i) & 1) == 1)) ones++;
        end
        return ones % 2;
    endfunction

    function automatic int nextState(input int s);
        return ((s * 2) % 256) + feedback(s);
    endfunction

    // Single comparison point: counts the vector and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("state", 32'(state), 32'(mState));
        checkOutput("out_valid", 32'(out_valid), 32'(mOutValid));
        checkOutput("out_data", 32'(out_data), 32'(mOutData));
        checkOutput("lockup", 32'(lockup), 32'(mLockup));
    endtask

    // Advance the model by one rising edge using the inputs currently applied
    task automatic modelEdge();
        int s;
        if (seed_load) begin
`ifdef LFSR_LOCKUP_GUARD_EN
            if (seed_in == 0) begin
                mState  = SEED;
                mLockup = 1'b1;
            end else begin
                mState = seed_in;
            end
`else
            mState = seed_in;
`endif
            mPhase    = P_IDLE;
            mOutValid = 1'b0;
        end else if (mPhase == P_IDLE) begin
            if (req_valid) begin
                mPhase = P_BUSY;
                mLeft  = OUT_W;
                mDraw  = 0;
                s      = mState;
                for (int k = 0; k < OUT_W; k++) begin
                    mDraw = mDraw * 2 + feedback(s);
                    s     = nextState(s);
                end
            end else if (step_en) begin
                mState = nextState(mState);
            end
        end else if (mPhase == P_BUSY) begin
            mState = nextState(mState);
            mLeft--;
            if (mLeft == 0) begin
                mPhase    = P_DONE;
                mOutValid = 1'b1;
                mOutData  = mDraw;
            end
        end else begin
            if (out_ready) begin
                mPhase    = P_IDLE;
                mOutValid = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, check handshake readiness, clock, then check outputs
    task automatic applyStimulus(input bit sl, input logic [7:0] si, input bit se, input bit rv, input bit ordy);
        seed_load = sl;
        seed_in   = si;
        step_en   = se;
        req_valid = rv;
        out_ready = ordy;
        #1;
        checkOutput("req_ready", 32'(req_ready), 32'((mPhase == P_IDLE) && !sl));
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
    endtask

    // Asynchronous reset applied between clock edges, released on a falling edge
    task automatic doReset();
        seed_load = 1'b0;
        seed_in   = '0;
        step_en   = 1'b0;
        req_valid = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        #1;
        mState    = SEED;
        mPhase    = P_IDLE;
        mLeft     = 0;
        mDraw     = 0;
        mOutData  = 0;
        mOutValid = 1'b0;
        mLockup   = 1'b0;
        checkOutput("rst_state", 32'(state), 32'(SEED));
        checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("rst_out_data", 32'(out_data), 32'(0));
        checkOutput("rst_lockup", 32'(lockup), 32'(0));
        checkOutput("rst_req_ready", 32'(req_ready), 32'(1));
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] stepSeq [4];
        bit         sl;
        logic [7:0] si;

        stepSeq[0] = 8'h70;
        stepSeq[1] = 8'hE0;
        stepSeq[2] = 8'hC0;
        stepSeq[3] = 8'h81;

        #2;
        doReset();

        // Free-run stepping from the reset seed
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkOutput("t1_step_seq", 32'(state), 32'(stepSeq[i]));
        end

        // Draw from reset: result after OUT_W cycles, held until consumed
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_accept_state", 32'(state), 32'(8'hB8));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("t2_early_valid", 32'(out_valid), 32'(0));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_valid", 32'(out_valid), 32'(1));
        checkOutput("t2_data", 32'(out_data), 32'(4'b0001));
        checkOutput("t2_state", 32'(state), 32'(8'h81));
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            checkOutput("t2_hold_valid", 32'(out_valid), 32'(1));
            checkOutput("t2_hold_data", 32'(out_data), 32'(4'b0001));
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_consumed", 32'(out_valid), 32'(0));
        seed_load = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("t2_req_ready", 32'(req_ready), 32'(1));

        // Seed load aborts an in-flight draw
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_load_state", 32'(state), 32'(8'h01));
        checkOutput("t3_load_valid", 32'(out_valid), 32'(0));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_step_state", 32'(state), 32'(8'h02));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            checkOutput("t3_no_valid", 32'(out_valid), 32'(0));
        end

        // step_en is ignored while a draw is shifting or waiting
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("t4_state", 32'(state), 32'(8'h81));
        checkOutput("t4_data", 32'(out_data), 32'(4'b0001));

        // All-zero seed handling
        doReset();
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef LFSR_LOCKUP_GUARD_EN
        checkOutput("t5_guard_state", 32'(state), 32'(8'hB8));
        checkOutput("t5_guard_lockup", 32'(lockup), 32'(1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkOutput("t5_lockup_sticky", 32'(lockup), 32'(1));
        end
        doReset();
`else
        checkOutput("t5_zero_state", 32'(state), 32'(8'h00));
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkOutput("t5_zero_stuck", 32'(state), 32'(8'h00));
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("t5_zero_valid", 32'(out_valid), 32'(1));
        checkOutput("t5_zero_data", 32'(out_data), 32'(0));
        checkOutput("t5_zero_lockup", 32'(lockup), 32'(0));
`endif

        // Asynchronous reset in the middle of a draw
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_idle_state", 32'(state), 32'(8'hB8));

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            sl = ($urandom_range(0, 11) == 0);
            si = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            applyStimulus(sl, si, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
